// File: rtl/instr_bundle_packer.sv
// Fetch-bundle write side: packs 32-bit words into a double-buffered 5-slot bundle.
// Optional idle auto-close of partial bundles: define PACKER_TIMEOUT_EN.
module instr_bundle_packer #(
  parameter int              SLOTS    = 5,
  parameter int              IW       = 32,
  parameter logic [IW-1:0]   NOP_WORD = 32'h00000013,
  parameter int              TIMEOUT  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [IW-1:0]       in_instr,
  input  logic                in_last,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [SLOTS*IW-1:0] out_bundle,
  output logic [3:0]          out_count
);

  localparam int BW = SLOTS * IW;
  localparam logic [3:0] LAST = 4'(SLOTS - 1);
  localparam logic [BW-1:0] FILL = {SLOTS{NOP_WORD}};

  logic [BW-1:0] asm_q, asm_d, asm_w;
  logic [3:0]    asm_cnt_q, asm_cnt_d, ccnt;
  logic          pending_q, pending_d;
  logic          out_valid_q, out_valid_d;
  logic [BW-1:0] out_bundle_q, out_bundle_d;
  logic [3:0]    out_count_q, out_count_d;
  logic          acc, slot_free, close, close_tmo, xfer;

`ifdef PACKER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] idle_q, idle_d;
`endif

  assign in_ready   = rst && !pending_q && !flush;
  assign out_valid  = out_valid_q;
  assign out_bundle = out_bundle_q;
  assign out_count  = out_count_q;

  always_comb begin
    acc       = in_valid && in_ready;
    slot_free = !out_valid_q || out_ready;
    asm_w     = asm_q;
    for (int k = 0; k < SLOTS; k++) begin
      if (acc && 4'(k) == asm_cnt_q) asm_w[k*IW +: IW] = in_instr;
    end
    ccnt = acc ? asm_cnt_q + 4'd1 : asm_cnt_q;
`ifdef PACKER_TIMEOUT_EN
    close_tmo = (asm_cnt_q != 4'd0) && !pending_q && !acc &&
                (idle_q == TW'(TIMEOUT - 1));
`else
    close_tmo = 1'b0;
`endif
    close = (acc && (in_last || asm_cnt_q == LAST)) || close_tmo;
    xfer  = slot_free && (close || pending_q);

    asm_d        = asm_q;
    asm_cnt_d    = asm_cnt_q;
    pending_d    = pending_q;
    out_valid_d  = out_valid_q;
    out_bundle_d = out_bundle_q;
    out_count_d  = out_count_q;

    if (flush) begin
      asm_d       = FILL;
      asm_cnt_d   = 4'd0;
      pending_d   = 1'b0;
      out_valid_d = 1'b0;
      out_count_d = 4'd0;
    end else if (xfer) begin
      out_valid_d  = 1'b1;
      out_bundle_d = asm_w;
      out_count_d  = ccnt;
      asm_d        = FILL;
      asm_cnt_d    = 4'd0;
      pending_d    = 1'b0;
    end else begin
      if (out_valid_q && out_ready) out_valid_d = 1'b0;
      // a closed bundle parks in the assembly buffer until the slot frees
      if (close) pending_d = 1'b1;
      if (acc) begin
        asm_d     = asm_w;
        asm_cnt_d = ccnt;
      end
    end
  end

`ifdef PACKER_TIMEOUT_EN
  always_comb begin
    idle_d = idle_q;
    if (flush || acc || close) idle_d = '0;
    else if (asm_cnt_q != 4'd0 && !pending_q) idle_d = idle_q + TW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) idle_q <= '0;
    else      idle_q <= idle_d;
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      asm_q        <= FILL;
      asm_cnt_q    <= 4'd0;
      pending_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      out_bundle_q <= '0;
      out_count_q  <= 4'd0;
    end else begin
      asm_q        <= asm_d;
      asm_cnt_q    <= asm_cnt_d;
      pending_q    <= pending_d;
      out_valid_q  <= out_valid_d;
      out_bundle_q <= out_bundle_d;
      out_count_q  <= out_count_d;
    end
  end

endmodule

// File: tb/tb_instr_bundle_packer.sv
// Bench for instr_bundle_packer: queue-level model checked every cycle,
// plus directed literal expectations.
module tb_instr_bundle_packer;

  localparam int SLOTS = 5;
  localparam int IW = 32;
  localparam int BW = SLOTS * IW;
  localparam logic [31:0] NOP = 32'h00000013;
  localparam int TIMEOUT = 8;

  logic clk = 0;
  logic rst = 0;
  logic in_valid = 0, in_last = 0, flush = 0, out_ready = 0;
  logic [IW-1:0] in_instr = '0;
  logic in_ready, out_valid;
  logic [BW-1:0] out_bundle;
  logic [3:0] out_count;

  int n_chk = 0;
  int n_pass = 0;

  instr_bundle_packer dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_last(in_last),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_bundle(out_bundle), .out_count(out_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [BW-1:0] got,
                     input logic [BW-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endtask

  // model: words collected so far, a held output register, a pending flag
  logic [31:0] m_asm[$];
  bit m_pend, m_ov;
  logic [BW-1:0] m_ob;
  int m_oc, m_idle;

  function automatic logic [BW-1:0] pack(input logic [31:0] q[$]);
    logic [BW-1:0] b;
    for (int i = 0; i < SLOTS; i++)
      b[i*IW +: IW] = (i < q.size()) ? q[i] : NOP;
    return b;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_asm.delete();
      m_pend = 0; m_ov = 0; m_ob = '0; m_oc = 0; m_idle = 0;
    end else if (flush) begin
      m_asm.delete();
      m_pend = 0; m_ov = 0; m_oc = 0; m_idle = 0;
    end else begin
      bit free, acc, closing;
      free = !m_ov || out_ready;
      acc = in_valid && !m_pend;
      closing = 0;
      if (acc) begin
        m_asm.push_back(in_instr);
        m_idle = 0;
        if (in_last || m_asm.size() == SLOTS) closing = 1;
      end else if (m_asm.size() > 0 && !m_pend) begin
`ifdef PACKER_TIMEOUT_EN
        m_idle++;
        if (m_idle == TIMEOUT) begin
          closing = 1;
          m_idle = 0;
        end
`endif
      end
      if ((closing || m_pend) && free) begin
        m_ov = 1;
        m_ob = pack(m_asm);
        m_oc = m_asm.size();
        m_asm.delete();
        m_pend = 0;
      end else begin
        if (m_ov && out_ready) m_ov = 0;
        if (closing) m_pend = 1;
      end
    end
  end

  always @(negedge clk) begin
    chk("out_valid", BW'(out_valid), BW'(m_ov));
    chk("in_ready", BW'(in_ready), BW'(rst && !m_pend && !flush));
    if (m_ov) begin
      chk("out_bundle", out_bundle, m_ob);
      chk("out_count", BW'(out_count), BW'(m_oc));
    end
  end

  task automatic step(input bit v, input logic [31:0] w, input bit l,
                      input bit f, input bit r);
    in_valid = v; in_instr = w; in_last = l; flush = f; out_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit r);
    step(0, 32'h0, 0, 0, r);
  endtask

  initial begin
    rst = 0;
    #1;
    chk("rst_in_ready", BW'(in_ready), BW'(0));
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", BW'(out_valid), BW'(0));
    chk("rst_out_count", BW'(out_count), BW'(0));
    chk("rst_out_bundle", out_bundle, BW'(0));
    rst = 1;
    #1;

    // full bundle
    for (int i = 1; i <= 5; i++) step(1, 32'(i * 'h11), 0, 0, 1);
    chk("full_valid", BW'(out_valid), BW'(1));
    chk("full_count", BW'(out_count), BW'(5));
    chk("full_bundle", out_bundle,
        160'h00000055_00000044_00000033_00000022_00000011);
    idle(1);
    chk("full_drained", BW'(out_valid), BW'(0));

    // partial close
    step(1, 32'hA1, 0, 0, 1);
    step(1, 32'hA2, 1, 0, 1);
    chk("part_count", BW'(out_count), BW'(2));
    chk("part_bundle", out_bundle,
        160'h00000013_00000013_00000013_000000A2_000000A1);
    idle(1);

    // backpressure
    for (int i = 1; i <= 10; i++) step(1, 32'(i), 0, 0, 0);
    chk("bp_in_ready", BW'(in_ready), BW'(0));
    chk("bp_held", out_bundle,
        160'h00000005_00000004_00000003_00000002_00000001);
    idle(0);
    chk("bp_stable", out_bundle,
        160'h00000005_00000004_00000003_00000002_00000001);
    idle(1);
    chk("bp_nobubble", BW'(out_valid), BW'(1));
    chk("bp_second", out_bundle,
        160'h0000000A_00000009_00000008_00000007_00000006);
    chk("bp_ready_back", BW'(in_ready), BW'(1));
    idle(1);
    chk("bp_drained", BW'(out_valid), BW'(0));

    // flush mid-bundle
    for (int i = 0; i < 3; i++) step(1, 32'hC1 + 32'(i), 0, 0, 1);
    step(1, 32'hC4, 0, 1, 1);
    chk("fl_valid", BW'(out_valid), BW'(0));
    for (int i = 0; i < 5; i++) step(1, 32'hD1 + 32'(i), 0, 0, 1);
    chk("fl_count", BW'(out_count), BW'(5));
    chk("fl_bundle", out_bundle,
        160'h000000D5_000000D4_000000D3_000000D2_000000D1);
    idle(1);

    // timeout or indefinite wait of a single word
    step(1, 32'hB1, 0, 0, 1);
    for (int i = 0; i < 7; i++) idle(1);
    chk("to_before", BW'(out_valid), BW'(0));
    idle(1);
`ifdef PACKER_TIMEOUT_EN
    chk("to_valid", BW'(out_valid), BW'(1));
    chk("to_count", BW'(out_count), BW'(1));
    chk("to_bundle", out_bundle,
        160'h00000013_00000013_00000013_00000013_000000B1);
    idle(1);
`else
    chk("to_none", BW'(out_valid), BW'(0));
    step(0, 32'h0, 0, 1, 1);
`endif

    // async reset with held bundle and pending bundle
    for (int i = 0; i < 10; i++) step(1, 32'hE0 + 32'(i), 0, 0, 0);
    chk("ar_pending", BW'(in_ready), BW'(0));
    #2 rst = 0;
    #1;
    chk("ar_valid", BW'(out_valid), BW'(0));
    chk("ar_in_ready", BW'(in_ready), BW'(0));
    chk("ar_count", BW'(out_count), BW'(0));
    in_valid = 0; out_ready = 1;
    @(posedge clk);
    #1 rst = 1;
    step(1, 32'hF1, 1, 0, 1);
    chk("ar_after", out_bundle,
        160'h00000013_00000013_00000013_00000013_000000F1);
    idle(1);
    idle(1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
